// File: rtl/alu_arbiter.sv
// alu_arbiter: one shared 32-bit ALU serving two valid/ready requesters.
// Operands are registered before the ALU and results after it, so a request
// taken in cycle C is answered from cycle C+2. One op is in flight at a time.
// Arbitration is round-robin (FIXED_PRIO=0) or requester 0 first (FIXED_PRIO=1).
// Optional feature macro: ALU_ARB_OVF_TRAP_EN. When it is defined, an ADD/SUB
// that overflows returns result 0 with rsp_trap=1. Otherwise rsp_trap is 0.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic                  rsp_trap
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  last_grant;
  logic                  grant_id;
  logic                  accept;

  logic [DATA_WIDTH-1:0] a_p0;
  logic [DATA_WIDTH-1:0] b_p0;
  logic [3:0]            op_p0;
  logic                  id_p0;

  logic [DATA_WIDTH+1:0] alu_out;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ovf;
  logic                  alu_carry;
  logic [DATA_WIDTH-1:0] res_final;
  logic                  trap_final;

  // Combinational ALU: returns {overflow, carry, result}. Shift amount is a[4:0]
  // and the shifted value is b. Unknown opcodes give zero with flags clear.
  function automatic logic [DATA_WIDTH+1:0] alu_eval(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [DATA_WIDTH:0]          wide;
    logic [DATA_WIDTH-1:0]        res;
    logic                         ovf;
    logic                         carry;
    logic [4:0]                   sh;
    sa    = a;
    sb    = b;
    sh    = a[4:0];
    wide  = '0;
    res   = '0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[DATA_WIDTH-1:0];
        carry = wide[DATA_WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_LUI:  res = b << 16;
      OP_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  res = b << sh;
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow (a < b).
        wide  = {1'b0, a} - {1'b0, b};
        res   = wide[DATA_WIDTH-1:0];
        carry = wide[DATA_WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_SRA:  res = sb >>> sh;
      OP_SRL:  res = b >> sh;
      default: res = '0;
    endcase
    return {ovf, carry, res};
  endfunction

  // State register; reset drops any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, grant selection and ready generation.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (FIXED_PRIO) grant_id = ~req0_valid;
    else if (req0_valid && req1_valid) grant_id = ~last_grant;
    else grant_id = req1_valid;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (req0_valid || req1_valid) begin
            accept     = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) accept = 1'b0;
    req0_ready = accept & ~grant_id;
    req1_ready = accept & grant_id;
  end

  // Remember the last winner so the other requester wins the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= grant_id;
  end

  // ---- stage p0: operand register fed from the granted requester ----
  // Operand capture on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= grant_id ? req1_a  : req0_a;
      b_p0  <= grant_id ? req1_b  : req0_b;
      op_p0 <= grant_id ? req1_op : req0_op;
      id_p0 <= grant_id;
    end
  end

  // ALU evaluation and overflow-trap substitution.
  always_comb begin
    alu_out   = alu_eval(op_p0, a_p0, b_p0);
    alu_res   = alu_out[DATA_WIDTH-1:0];
    alu_carry = alu_out[DATA_WIDTH];
    alu_ovf   = alu_out[DATA_WIDTH+1];
`ifdef ALU_ARB_OVF_TRAP_EN
    trap_final = alu_ovf;
    res_final  = alu_ovf ? '0 : alu_res;
`else
    trap_final = 1'b0;
    res_final  = alu_res;
`endif
  end

  // ---- stage p1: response register, loaded in EXEC and held through RESP ----
  // Response capture; outputs stay put until the consumer takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_trap     <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id       <= id_p0;
      rsp_result   <= res_final;
      rsp_overflow <= alu_ovf;
      rsp_carry    <= alu_carry;
      rsp_zero     <= (res_final == '0);
      rsp_trap     <= trap_final;
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed bench for alu_arbiter with a
// queue-based reference model of arbitration, latency and ALU results.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_carry, rsp_zero, rsp_trap;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_trap(rsp_trap)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        ovf;
    logic        carry;
    logic        zero;
    logic        trap;
    int          t;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  exp_t        q[$];
  logic        gq[$];
  int          cyc;
  int          n_pass;
  int          n_checks;
  logic        mdl_last;

  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic [3:0]  op[2];
  logic        acc[2];
  logic        rr;
  bit          auto_mode;
  bit          rr_rand;
  int          pv;
  int          fop[2];

  logic        s_valid, s_rdy0, s_rdy1, s_id, s_ovf, s_carry, s_zero, s_trap;
  logic [31:0] s_res;

  assign req0_valid = v[0];
  assign req0_a     = a[0];
  assign req0_b     = b[0];
  assign req0_op    = op[0];
  assign req1_valid = v[1];
  assign req1_a     = a[1];
  assign req1_b     = b[1];
  assign req1_op    = op[1];
  assign rsp_ready  = rr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference ALU computed from the opcode rules with wide integer arithmetic.
  function automatic exp_t ref_op(input logic id, input logic [3:0] o,
                                  input logic [31:0] x, input logic [31:0] y);
    exp_t               e;
    longint             us;
    longint             ss;
    logic signed [31:0] ys;
    logic [4:0]         sh;
    e.id = id; e.res = 0; e.ovf = 0; e.carry = 0; e.trap = 0; e.t = 0;
    sh = x[4:0];
    ys = y;
    case (o)
      4'd0:  e.res = x & y;
      4'd1:  e.res = x | y;
      4'd2: begin
        us = longint'(x) + longint'(y);
        ss = longint'($signed(x)) + longint'($signed(y));
        e.res   = x + y;
        e.carry = (us > 64'sh0000_0000_FFFF_FFFF);
        e.ovf   = (ss > SMAX) || (ss < SMIN);
      end
      4'd3:  e.res = {y[15:0], 16'h0000};
      4'd4:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd5:  e.res = y << sh;
      4'd6: begin
        ss = longint'($signed(x)) - longint'($signed(y));
        e.res   = x - y;
        e.carry = (x < y);
        e.ovf   = (ss > SMAX) || (ss < SMIN);
      end
      4'd7:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  e.res = ~(x | y);
      4'd10: e.res = x ^ y;
      4'd11: e.res = ys >>> sh;
      4'd12: e.res = y >> sh;
      default: e.res = 0;
    endcase
`ifdef ALU_ARB_OVF_TRAP_EN
    if (e.ovf) begin
      e.trap = 1'b1;
      e.res  = 0;
    end
`endif
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_op(input int i);
    v[i]  = ($urandom_range(0, 99) < pv);
    a[i]  = pick();
    b[i]  = pick();
    op[i] = (fop[i] < 0) ? 4'($urandom_range(0, 15)) : 4'(fop[i]);
  endtask

  task automatic issue(input int i, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    v[i] = 1'b1; op[i] = o; a[i] = x; b[i] = y;
  endtask

  // Negedge observation: compare the DUT against the model and advance the model.
  task automatic monitor();
    logic any, g, allow, ev;
    exp_t e;
    s_valid = rsp_valid; s_rdy0 = req0_ready; s_rdy1 = req1_ready; s_id = rsp_id;
    s_res = rsp_result; s_ovf = rsp_overflow; s_carry = rsp_carry;
    s_zero = rsp_zero; s_trap = rsp_trap;
    acc[0] = v[0] && req0_ready;
    acc[1] = v[1] && req1_ready;
    if (reset) return;
    any   = v[0] | v[1];
    g     = (v[0] && v[1]) ? ~mdl_last : v[1];
    allow = any && (q.size() == 0 || (rsp_valid && rr));
    check("req0_ready", 32'(req0_ready), 32'(allow && !g));
    check("req1_ready", 32'(req1_ready), 32'(allow && g));
    check("both_ready", 32'(req0_ready & req1_ready), 32'd0);
    ev = (q.size() > 0) && (cyc - q[0].t >= 2);
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (rsp_valid && q.size() > 0) begin
      check("rsp_id",       32'(rsp_id),       32'(q[0].id));
      check("rsp_result",   rsp_result,        q[0].res);
      check("rsp_overflow", 32'(rsp_overflow), 32'(q[0].ovf));
      check("rsp_carry",    32'(rsp_carry),    32'(q[0].carry));
      check("rsp_zero",     32'(rsp_zero),     32'(q[0].zero));
      check("rsp_trap",     32'(rsp_trap),     32'(q[0].trap));
      if (rr) void'(q.pop_front());
    end
    if (allow) begin
      e   = ref_op(g, op[g], a[g], b[g]);
      e.t = cyc;
      q.push_back(e);
      gq.push_back(g);
      mdl_last = g;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        if (auto_mode) new_op(i);
        else v[i] = 1'b0;
      end else if (auto_mode && !v[i]) begin
        new_op(i);
      end
    end
    if (rr_rand) rr = ($urandom_range(0, 99) < 70);
  endtask

  task automatic wait_rsp(input int maxc);
    int n = 0;
    do begin
      run_cycle();
      n++;
    end while (!s_valid && n < maxc);
    if (!s_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int i, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(i, o, x, y);
    wait_rsp(8);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    q.delete();
    mdl_last = 1'b1;
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    auto_mode = 1'b0; rr_rand = 1'b0; rr = 1'b1;
    repeat (n) run_cycle();
  endtask

  initial begin
    n_pass = 0; n_checks = 0; cyc = 0; mdl_last = 1'b1;
    auto_mode = 1'b0; rr_rand = 1'b0; pv = 100; fop[0] = -1; fop[1] = -1;
    acc[0] = 1'b0; acc[1] = 1'b0;
    v[0] = 1'b1; v[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin a[i] = 0; b[i] = 0; op[i] = 0; end
    rr = 1'b1;
    reset = 1'b1;

    // Reset state with both requesters asking.
    @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_result", rsp_result,      32'd0);
    check("rst_rsp_flags",  32'({rsp_id, rsp_overflow, rsp_carry, rsp_zero, rsp_trap}), 32'd0);
    do_reset();

    // Single ADD from requester 0.
    issue(0, 4'd2, 32'd5, 32'd7);
    run_cycle();
    check("add_accept", 32'(s_rdy0), 32'd1);
    wait_rsp(4);
    check("add_id",     32'(s_id),   32'd0);
    check("add_result", s_res,       32'd12);
    check("add_zero",   32'(s_zero), 32'd0);
    check("add_flags",  32'({s_ovf, s_carry, s_trap}), 32'd0);
    drain(2);

    // Overflowing subtract.
    run_op(0, 4'd6, 32'h8000_0000, 32'd1);
    check("sub_ovf",   32'(s_ovf),   32'd1);
    check("sub_carry", 32'(s_carry), 32'd0);
`ifdef ALU_ARB_OVF_TRAP_EN
    check("sub_trap",   32'(s_trap), 32'd1);
    check("sub_result", s_res,       32'd0);
`else
    check("sub_trap",   32'(s_trap), 32'd0);
    check("sub_result", s_res,       32'h7FFF_FFFF);
`endif
    drain(2);

    // Shift, unsigned compare, unknown opcode.
    run_op(1, 4'd11, 32'd4, 32'h8000_0000);
    check("sra_result", s_res, 32'hF800_0000);
    check("sra_id", 32'(s_id), 32'd1);
    drain(2);
    run_op(0, 4'd4, 32'd1, 32'hFFFF_FFFF);
    check("sltu_result", s_res, 32'd1);
    drain(2);
    run_op(0, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    check("unk_result", s_res, 32'd0);
    check("unk_zero", 32'(s_zero), 32'd1);
    drain(2);

    // Backpressure: response held while requester 1 waits.
    rr = 1'b0;
    run_op(0, 4'd2, 32'd1, 32'd2);
    issue(1, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    repeat (5) run_cycle();
    check("bp_req1_wait", 32'(s_rdy1), 32'd0);
    check("bp_hold_result", s_res, 32'd3);
    rr = 1'b1;
    run_cycle();
    check("bp_req1_accept", 32'(s_rdy1), 32'd1);
    wait_rsp(4);
    check("bp_and_result", s_res, 32'hF000_F000);
    drain(2);

    // Round-robin with both requesters continuously valid.
    do_reset();
    gq.delete();
    auto_mode = 1'b1; pv = 100; fop[0] = 10; fop[1] = 1;
    new_op(0); new_op(1);
    repeat (12) run_cycle();
    check("rr_count", 32'(gq.size() >= 4), 32'd1);
    if (gq.size() >= 4) begin
      check("rr_g0", 32'(gq[0]), 32'd0);
      check("rr_g1", 32'(gq[1]), 32'd1);
      check("rr_g2", 32'(gq[2]), 32'd0);
      check("rr_g3", 32'(gq[3]), 32'd1);
    end
    drain(10);

    // Random traffic with random backpressure.
    do_reset();
    auto_mode = 1'b1; rr_rand = 1'b1; pv = 60; fop[0] = -1; fop[1] = -1;
    repeat (1500) run_cycle();
    drain(20);
    check("drain_empty", 32'(q.size()), 32'd0);

    // Reset while an op sits in EXEC.
    do_reset();
    issue(0, 4'd2, 32'd3, 32'd4);
    run_cycle();
    check("mid_accept", 32'(s_rdy0), 32'd1);
    issue(0, 4'd10, 32'h0000_00FF, 32'h0000_0F0F);
    issue(1, 4'd1,  32'h0000_1000, 32'h0000_0001);
    reset = 1'b1;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_ready0", 32'(req0_ready), 32'd0);
    check("mid_ready1", 32'(req1_ready), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    q.delete();
    mdl_last = 1'b1;
    reset = 1'b0;
    run_cycle();
    check("mid_first_grant0", 32'(s_rdy0), 32'd1);
    wait_rsp(4);
    check("mid_xor_result", s_res, 32'h0000_0FF0);
    drain(8);
    check("mid_drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
